// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming-distance unit.
//   clog2      - ceiling log2, usable in parameter and port-width expressions
//   sat_max    - clamps a count to the largest value a DIST_W-bit field holds
//   DEFAULT_*  - default operand and distance widths
package hamming_pkg;

    localparam int DEFAULT_WIDTH  = 6;
    localparam int DEFAULT_DIST_W = 2;

    // Smallest r with 2**r >= n (clog2(1) = 0).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Clamp value to 2**dist_w - 1.
    function automatic int unsigned sat_max(input int unsigned value,
                                            input int unsigned dist_w);
        int unsigned max_v;
        max_v = (32'd1 << dist_w) - 32'd1;
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count built as a balanced adder tree.
// The vector is split in two halves, each half is counted by a smaller
// instance of this module, and the two partial counts are added. The
// recursion ends at single bits, so the tree depth is clog2(WIDTH).
//   vec_i   [WIDTH-1:0]            vector to count
//   count_o [clog2(WIDTH+1)-1:0]   number of ones in vec_i
module popcount
    import hamming_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]                vec_i,
    output logic [clog2(WIDTH+1)-1:0]       count_o
);

    localparam int CNT_W = clog2(WIDTH + 1);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count_o = vec_i;
        end else begin : g_split
            localparam int LO_W = WIDTH / 2;
            localparam int HI_W = WIDTH - LO_W;

            logic [clog2(LO_W+1)-1:0] lo_cnt;
            logic [clog2(HI_W+1)-1:0] hi_cnt;

            popcount #(.WIDTH(LO_W)) u_lo (
                .vec_i   (vec_i[LO_W-1:0]),
                .count_o (lo_cnt)
            );

            popcount #(.WIDTH(HI_W)) u_hi (
                .vec_i   (vec_i[WIDTH-1:LO_W]),
                .count_o (hi_cnt)
            );

            // CNT_W is sized for WIDTH ones, so the sum cannot overflow.
            assign count_o = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/hamming_distance.sv
// Two-stage pipelined Hamming-distance unit.
// Stage 1 registers the XOR of the operands; stage 2 counts the differing
// bits, saturates the count to DIST_W bits and registers the result.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   binary1/binary2 are sampled on this edge
//   binary1    first operand  [WIDTH-1:0]
//   binary2    second operand [WIDTH-1:0]
//   out_valid  distance/saturated carry a new result this cycle
//   distance   saturated count of differing bits [DIST_W-1:0]
//   saturated  true count exceeded 2**DIST_W - 1
module hamming_distance
    import hamming_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIST_W = DEFAULT_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  binary1,
    input  logic [WIDTH-1:0]  binary2,
    output logic              out_valid,
    output logic [DIST_W-1:0] distance,
    output logic              saturated
);

    localparam int          CNT_W    = clog2(WIDTH + 1);
    localparam int unsigned MAX_DIST = (32'd1 << DIST_W) - 32'd1;

    // Stage 1: operand difference
    logic [WIDTH-1:0] diff_d, diff_q;
    logic             s1_valid_q;

    // Stage 2: count and saturation
    logic [CNT_W-1:0]  count;
    logic [DIST_W-1:0] distance_d, distance_q;
    logic              saturated_d, saturated_q;
    logic              out_valid_q;

    assign diff_d = binary1 ^ binary2;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                diff_q <= diff_d;
            end
        end
    end

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec_i   (diff_q),
        .count_o (count)
    );

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no
        // latch can be inferred.
        distance_d = DIST_W'(sat_max(32'(count), unsigned'(DIST_W)));
    end

    // When the distance field can represent WIDTH, saturation is impossible.
    generate
        if (DIST_W >= CNT_W) begin : g_no_sat
            assign saturated_d = 1'b0;
        end else begin : g_sat
            assign saturated_d = (32'(count) > MAX_DIST);
        end
    endgenerate

    // Result registers update only for valid data, so bubbles leave the last
    // distance/saturated visible while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            distance_q  <= '0;
            saturated_q <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                distance_q  <= distance_d;
                saturated_q <= saturated_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign distance  = distance_q;
    assign saturated = saturated_q;

endmodule

// File: tb/tb_hamming_distance.sv
// Self-checking bench for hamming_distance (WIDTH=6, DIST_W=2).
// Inputs change on the falling edge; outputs are checked 1 ns after each
// rising edge against a reference that counts differing bit positions.
module tb_hamming_distance;

    localparam int W  = 6;
    localparam int DW = 2;
    localparam int MAXD = (1 << DW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  binary1;
    logic [W-1:0]  binary2;
    logic          out_valid;
    logic [DW-1:0] distance;
    logic          saturated;

    int n_checks;
    int n_fail;

    // Reference state: the pair sampled on the previous edge and the
    // currently expected (held) outputs.
    logic          pend_v;
    logic [W-1:0]  pend_a, pend_b;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_s;

    hamming_distance #(.WIDTH(W), .DIST_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .binary1   (binary1),
        .binary2   (binary2),
        .out_valid (out_valid),
        .distance  (distance),
        .saturated (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_count(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (a[i] != b[i]) n++;
        end
        return n;
    endfunction

    task automatic clear_model();
        pend_v = 1'b0;
        pend_a = '0;
        pend_b = '0;
        exp_v  = 1'b0;
        exp_d  = '0;
        exp_s  = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        n_checks++;
        if (out_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_v);
        end
        n_checks++;
        if (distance !== exp_d) begin
            n_fail++;
            $display("FAIL %s distance: got %0d expected %0d", tag, distance, exp_d);
        end
        n_checks++;
        if (saturated !== exp_s) begin
            n_fail++;
            $display("FAIL %s saturated: got %b expected %b", tag, saturated, exp_s);
        end
    endtask

    // One clock cycle: drive on the falling edge, advance the reference on the
    // rising edge, compare shortly after it.
    task automatic cycle(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag);
        int c;
        @(negedge clk);
        in_valid = v;
        binary1  = a;
        binary2  = b;
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            exp_v = pend_v;
            if (pend_v) begin
                c     = ref_count(pend_a, pend_b);
                exp_d = DW'((c > MAXD) ? MAXD : c);
                exp_s = (c > MAXD);
            end
            pend_v = v;
            pend_a = a;
            pend_b = b;
        end
        #1;
        compare_outputs(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        binary1  = '0;
        binary2  = '0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 6'h15, 6'h2a, "reset_hold");
        end
        release_reset();
        cycle(1'b0, '0, '0, "reset_release");
    endtask

    task automatic test_directed();
        cycle(1'b1, 6'b101010, 6'b111111, "dir_three");
        cycle(1'b1, 6'b000001, 6'b000000, "dir_one");
        cycle(1'b1, 6'b000000, 6'b111111, "dir_sat");
        cycle(1'b1, 6'b110011, 6'b110011, "dir_equal");
        cycle(1'b1, 6'b100000, 6'b010000, "dir_two");
        cycle(1'b0, '0, '0, "dir_drain1");
        cycle(1'b0, '0, '0, "dir_drain2");
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 6'b000111, 6'b000000, "b2b_p0");
        cycle(1'b1, 6'b000011, 6'b000000, "b2b_p1");
        cycle(1'b0, 6'b111111, 6'b000000, "b2b_gap");
        cycle(1'b1, 6'b011111, 6'b000000, "b2b_p2");
        cycle(1'b0, '0, '0, "b2b_drain1");
        cycle(1'b0, '0, '0, "b2b_drain2");
        cycle(1'b0, '0, '0, "b2b_hold");
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 6'b000000, 6'b111111, "async_load");
        cycle(1'b0, '0, '0, "async_visible");
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        compare_outputs("async_clear");
        cycle(1'b1, 6'h3f, 6'h00, "async_hold");
        release_reset();
        cycle(1'b0, '0, '0, "async_after");
    endtask

    task automatic test_reset_inflight();
        cycle(1'b1, 6'b000000, 6'b111111, "flight_p0");
        in_valid = 1'b1;
        binary1  = 6'b000001;
        binary2  = 6'b000000;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        compare_outputs("flight_drop");
        cycle(1'b1, 6'b000011, 6'b000000, "flight_in_reset1");
        cycle(1'b1, 6'b000111, 6'b000000, "flight_in_reset2");
        release_reset();
        cycle(1'b1, 6'b110000, 6'b000000, "flight_new");
        cycle(1'b0, '0, '0, "flight_lat1");
        cycle(1'b0, '0, '0, "flight_lat2");
        cycle(1'b0, '0, '0, "flight_idle");
    endtask

    task automatic test_random();
        logic          v;
        logic [W-1:0]  a, b;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(3, 0) != 0);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(7, 0) == 0) b = a;
            cycle(v, a, b, "random");
        end
        cycle(1'b0, '0, '0, "random_drain1");
        cycle(1'b0, '0, '0, "random_drain2");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
